// File: rtl/out_port_fifo.sv
// out_port_fifo: queues OUT-instruction bus words with a channel tag and drains them per channel.
// Latency: a write at edge N is presented on port_valid/port_data after edge N+1; each pop is followed by one idle cycle.
// Backpressure: a not-ready head channel stalls all later entries; busy marks a full queue, and writes while full are dropped and set ovf.
// Optional feature macro: OUT_PORT_READBACK_EN adds rb_sel/rb_data, the last value popped per channel.
module out_port_fifo #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              out_in,
  output logic [DATA_W-1:0] port_data,
  output logic [NUM_CH-1:0] port_valid,
  input  logic [NUM_CH-1:0] port_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef OUT_PORT_READBACK_EN
  ,
  input  logic [CH_W-1:0]   rb_sel,
  output logic [DATA_W-1:0] rb_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] dat;
  } ent_t;

  ent_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  ent_t              head;
  logic              full;
  logic              ch_ok;
  logic              wr_ok;
  logic              drop;
  logic              pop;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_CH-1:0] head_onehot;

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign ch_ok = ({1'b0, ch_sel} < (CH_W+1)'(NUM_CH));
  // Full blocks the write even if a pop happens on the same edge.
  assign wr_ok = out_in & ~full & ch_ok;
  assign drop  = out_in & ~wr_ok;
  // port_valid is only ever set for a queued head, so a pop can never underflow.
  assign pop   = |(port_valid & port_ready);
  assign cnt_nxt = count + CNT_W'(wr_ok) - CNT_W'(pop);

  // Decode the head entry's channel tag into a one-hot valid vector.
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (head.ch == CH_W'(i)) head_onehot[i] = 1'b1;
    end
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {ch_sel, bus_in};
  end

  // Pointers, occupancy, full flag and sticky overflow.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= cnt_nxt;
      busy  <= (cnt_nxt == CNT_W'(DEPTH));
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Registered head presentation: idle for the cycle after a pop so the
  // advanced read pointer is picked up next edge; data holds while empty.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      port_valid <= '0;
      port_data  <= '0;
    end else if (!pop && (count != '0)) begin
      port_valid <= head_onehot;
      port_data  <= head.dat;
    end else begin
      port_valid <= '0;
    end
  end

`ifdef OUT_PORT_READBACK_EN
  logic [DATA_W-1:0] last_val [NUM_CH];

  // Remember the word most recently handed to each channel.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_CH; i++) last_val[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (port_valid[i] && port_ready[i]) last_val[i] <= port_data;
      end
    end
  end

  // Readback mux; an out-of-range select reads zero.
  always_comb begin
    rb_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rb_sel == CH_W'(i)) rb_data = last_val[i];
    end
  end
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: queue-based reference model checked every cycle plus directed literal checks.
module tb_out_port_fifo;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] bus_in = '0;
  logic [CH_W-1:0]   ch_sel = '0;
  logic              out_in = 1'b0;
  logic [DATA_W-1:0] port_data;
  logic [NUM_CH-1:0] port_valid;
  logic [NUM_CH-1:0] port_ready = '0;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              ovf_clr = 1'b0;
`ifdef OUT_PORT_READBACK_EN
  logic [CH_W-1:0]   rb_sel = '0;
  logic [DATA_W-1:0] rb_data;
`endif

  always #5 clk = ~clk;

  out_port_fifo #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .ch_sel(ch_sel), .out_in(out_in),
    .port_data(port_data), .port_valid(port_valid), .port_ready(port_ready),
    .busy(busy), .count(count), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef OUT_PORT_READBACK_EN
    , .rb_sel(rb_sel), .rb_data(rb_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] dat;
  } ent_t;

  ent_t              q[$];
  logic [DATA_W-1:0] popped[$];
  logic              m_vld = 1'b0;
  logic [CH_W-1:0]   m_ch  = '0;
  logic [DATA_W-1:0] m_dat = '0;
  logic              m_ovf = 1'b0;
  logic [DATA_W-1:0] m_last [NUM_CH];
  logic              m_pop;
  logic              m_wr;
  int                m_sz;
  ent_t              m_tmp;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      q.delete();
      m_vld = 1'b0;
      m_dat = '0;
      m_ovf = 1'b0;
      for (int i = 0; i < NUM_CH; i++) m_last[i] = '0;
    end else begin
      m_sz  = q.size();
      m_pop = m_vld && port_ready[m_ch];
      m_wr  = out_in && (m_sz < DEPTH) && (int'(ch_sel) < NUM_CH);
      if (out_in && !m_wr) m_ovf = 1'b1;
      else if (ovf_clr)    m_ovf = 1'b0;
      if (m_pop) begin
        m_last[m_ch] = m_dat;
        popped.push_back(m_dat);
      end
      // Head shown the edge after it is queued, idle for one cycle after a pop.
      if (m_sz > 0 && !m_pop) begin
        m_vld = 1'b1;
        m_ch  = q[0].ch;
        m_dat = q[0].dat;
      end else begin
        m_vld = 1'b0;
      end
      if (m_pop) void'(q.pop_front());
      if (m_wr) begin
        m_tmp = {ch_sel, bus_in};
        q.push_back(m_tmp);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("count", count, q.size());
    check("busy", busy, q.size() == DEPTH);
    check("ovf", ovf, m_ovf);
    check("port_valid", port_valid, m_vld ? (NUM_CH'(1) << m_ch) : '0);
    check("port_data", port_data, m_dat);
`ifdef OUT_PORT_READBACK_EN
    check("rb_data", rb_data, m_last[rb_sel]);
`endif
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // 1: reset held with strobe active
    clr = 1'b0; out_in = 1'b1; bus_in = 32'hDEAD; ch_sel = 2'd1;
    tick(3);
    check("t1_count", count, 0);
    check("t1_valid", port_valid, 4'b0000);
    check("t1_busy", busy, 0);
    check("t1_ovf", ovf, 0);
    out_in = 1'b0; clr = 1'b1;
    tick(2);
    check("t1_no_spurious", count, 0);

    // 2: single OUT on channel 2
    bus_in = 32'h0000_00A5; ch_sel = 2'd2; out_in = 1'b1; port_ready = 4'b0000;
    tick();
    out_in = 1'b0;
    check("t2_count1", count, 1);
    check("t2_not_yet_valid", port_valid, 4'b0000);
    tick();
    check("t2_valid", port_valid, 4'b0100);
    check("t2_data", port_data, 32'hA5);
    port_ready = 4'b0100;
    tick();
    port_ready = 4'b0000;
    check("t2_count0", count, 0);
    check("t2_valid_clr", port_valid, 4'b0000);
    check("t2_hold_data", port_data, 32'hA5);

    // 3: fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) begin
      bus_in = 32'h100 + i; ch_sel = CH_W'(i % NUM_CH); out_in = 1'b1;
      tick();
    end
    check("t3_busy", busy, 1);
    check("t3_count8", count, 8);
    bus_in = 32'hFF; ch_sel = 2'd0;
    tick();
    out_in = 1'b0;
    check("t3_ovf", ovf, 1);
    check("t3_count_still8", count, 8);
    popped.delete();
    port_ready = 4'b1111;
    tick(20);
    check("t3_drained", popped.size(), 8);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      check("t3_order", popped[i], 32'h100 + i);
    check("t3_empty", count, 0);
    port_ready = 4'b0000;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", ovf, 0);

    // 4: simultaneous write and pop, then stream through the wrap
    popped.delete();
    for (int i = 0; i < 3; i++) begin
      bus_in = 32'h200 + i; ch_sel = 2'd1; out_in = 1'b1;
      tick();
    end
    out_in = 1'b0;
    tick();
    check("t4_head_valid", port_valid, 4'b0010);
    bus_in = 32'h203; ch_sel = 2'd1; out_in = 1'b1; port_ready = 4'b0010;
    tick();
    check("t4_simul_count", count, 3);
    for (int i = 4; i < 10; i++) begin
      bus_in = 32'h200 + i;
      tick();
    end
    out_in = 1'b0;
    tick(30);
    check("t4_drained", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      check("t4_order", popped[i], 32'h200 + i);
    check("t4_no_ovf", ovf, 0);
    port_ready = 4'b0000;

    // 5: mixed channels, head-of-line blocking
    popped.delete();
    port_ready = 4'b0010;
    ch_sel = 2'd0; bus_in = 32'h11; out_in = 1'b1; tick();
    ch_sel = 2'd1; bus_in = 32'h22; tick();
    ch_sel = 2'd0; bus_in = 32'h33; tick();
    out_in = 1'b0;
    tick(5);
    check("t5_blocked_count", count, 3);
    check("t5_head_ch0", port_valid, 4'b0001);
    check("t5_head_data", port_data, 32'h11);
    port_ready = 4'b0011;
    tick(10);
    check("t5_drained", popped.size(), 3);
    if (popped.size() == 3) begin
      check("t5_first", popped[0], 32'h11);
      check("t5_second", popped[1], 32'h22);
      check("t5_third", popped[2], 32'h33);
    end
    port_ready = 4'b0000;

    // 6: clear and drop in the same cycle; readback of channel 3
    for (int i = 0; i < DEPTH; i++) begin
      bus_in = (i == DEPTH - 1) ? 32'h5A : 32'h300 + i; ch_sel = 2'd3; out_in = 1'b1;
      tick();
    end
    check("t6_ovf_pre", ovf, 0);
    bus_in = 32'hFF; ovf_clr = 1'b1;
    tick();
    out_in = 1'b0; ovf_clr = 1'b0;
    check("t6_set_wins", ovf, 1);
    popped.delete();
    port_ready = 4'b1000;
    tick(25);
    check("t6_drained", popped.size(), 8);
    check("t6_empty", count, 0);
    port_ready = 4'b0000;
`ifdef OUT_PORT_READBACK_EN
    rb_sel = 2'd3;
    #1;
    check("t6_rb_ch3", rb_data, 32'h5A);
    rb_sel = 2'd0;
    #1;
    check("t6_rb_ch0", rb_data, 32'h33);
`endif

    // Reset in the middle of a pending handshake discards the queue.
    ch_sel = 2'd2; bus_in = 32'h77; out_in = 1'b1;
    tick(3);
    out_in = 1'b0;
    tick();
    check("t7_pending", port_valid, 4'b0100);
    clr = 1'b0;
    #1;
    check("t7_rst_count", count, 0);
    check("t7_rst_valid", port_valid, 4'b0000);
    check("t7_rst_data", port_data, 0);
    tick();
    clr = 1'b1;
    tick(2);
    check("t7_stays_empty", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
